// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: handshaked byte-addressable data memory for the MEM stage.
// Accepts one load/store per handshake and returns a registered response
// WAIT_CYCLES+1 cycles later, with sign/zero extension and error checking.
module data_mem_ctrl #(
  parameter int    DEPTH_BYTES = 256,
  parameter int    ADDR_W      = 8,
  parameter int    WAIT_CYCLES = 0,
  parameter bit    ALIGN_CHECK = 1'b1,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [2:0]        load_type_i,
  input  logic [1:0]        store_type_i,
  output logic              resp_valid_o,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_err_o,
  output logic              busy_o
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH_BYTES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [2:0]          ltype_q, ltype_d;
  logic [1:0]          stype_q, stype_d;
  logic                resp_valid_q, resp_valid_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [7:0]          mem_q [DEPTH_BYTES];

  logic                accept, enter_resp, commit;
  logic                a_we;
  logic [ADDR_W-1:0]   a_addr;
  logic [31:0]         a_wdata;
  logic [2:0]          a_ltype;
  logic [1:0]          a_stype;
  logic [2:0]          a_size;
  logic                a_illegal, a_range_err, a_misaligned, a_err;
  logic [ADDR_W:0]     a_end;
  logic [IDX_W-1:0]    b_idx [4];
  logic [ADDR_W-1:0]   b_addr;
  logic [31:0]         rd_raw, load_data;

  assign req_ready_o  = (state_q == ST_IDLE) || (state_q == ST_RESP);
  assign busy_o       = (state_q != ST_IDLE);
  assign accept       = req_valid_i && req_ready_o;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

  // Access being performed: captured request in WAIT, live request when it
  // goes straight to RESP on its accepting edge (WAIT_CYCLES = 0).
  always_comb begin
    a_we    = (state_q == ST_WAIT) ? we_q    : req_we_i;
    a_addr  = (state_q == ST_WAIT) ? addr_q  : req_addr_i;
    a_wdata = (state_q == ST_WAIT) ? wdata_q : req_wdata_i;
    a_ltype = (state_q == ST_WAIT) ? ltype_q : load_type_i;
    a_stype = (state_q == ST_WAIT) ? stype_q : store_type_i;
    a_illegal = 1'b0;
    a_size    = 3'd1;
    if (a_we) begin
      case (a_stype)
        2'd0:    a_size = 3'd1;
        2'd1:    a_size = 3'd2;
        2'd2:    a_size = 3'd4;
        default: a_illegal = 1'b1;
      endcase
    end else begin
      case (a_ltype)
        3'd0, 3'd4: a_size = 3'd1;
        3'd1, 3'd5: a_size = 3'd2;
        3'd2:       a_size = 3'd4;
        default:    a_illegal = 1'b1;
      endcase
    end
    a_end        = {1'b0, a_addr} + (ADDR_W+1)'(a_size) - (ADDR_W+1)'(1);
    a_range_err  = (a_end >= DEPTH_C);
    a_misaligned = ((a_size == 3'd2) && a_addr[0]) ||
                   ((a_size == 3'd4) && (a_addr[1:0] != 2'b00));
    a_err        = a_illegal || a_range_err || (ALIGN_CHECK && a_misaligned);
  end

  // Byte lanes of the access, little-endian; lanes beyond the size read 0.
  always_comb begin
    rd_raw = 32'h0;
    b_addr = '0;
    for (int k = 0; k < 4; k++) begin
      b_addr   = a_addr + ADDR_W'(k);
      b_idx[k] = b_addr[IDX_W-1:0];
      if (!a_err && (3'(k) < a_size)) rd_raw[8*k +: 8] = mem_q[b_idx[k]];
    end
    case (a_size)
      3'd1:    load_data = a_ltype[2] ? {24'h0, rd_raw[7:0]}
                                      : {{24{rd_raw[7]}}, rd_raw[7:0]};
      3'd2:    load_data = a_ltype[2] ? {16'h0, rd_raw[15:0]}
                                      : {{16{rd_raw[15]}}, rd_raw[15:0]};
      default: load_data = rd_raw;
    endcase
  end

  // Next-state, counter, request capture and response formation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ltype_d    = ltype_q;
    stype_d    = stype_q;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          we_d    = req_we_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          ltype_d = load_type_i;
          stype_d = store_type_i;
          cnt_d   = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
          end else begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d    = ST_RESP;
          cnt_d      = 4'd0;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    commit       = enter_resp && a_we && !a_err;
    resp_valid_d = enter_resp;
    rdata_d      = enter_resp ? ((a_we || a_err) ? 32'h0 : load_data) : rdata_q;
    err_d        = enter_resp ? a_err : err_q;
  end

  // Control and response registers; reset returns to IDLE with quiet outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      ltype_q      <= 3'd0;
      stype_q      <= 2'd0;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'h0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      ltype_q      <= ltype_d;
      stype_q      <= stype_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // Store commit on the edge entering RESP; the array is never reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < a_size) mem_q[b_idx[k]] <= a_wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: three instances (WAIT 0/3/2, ALIGN 1/1/0) driven
// with directed and random requests against a byte-array reference model.
module tb_data_mem_ctrl;

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [2:0]  lt;
    logic [1:0]  st;
  } req_t;

  logic clk;
  logic        rst_n      [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_we     [3];
  logic [7:0]  req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic [2:0]  ltype      [3];
  logic [1:0]  stype      [3];
  logic        resp_valid [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err   [3];
  logic        busy       [3];

  int wc [3] = '{0, 3, 2};
  bit ac [3] = '{1'b1, 1'b1, 1'b0};

  logic [7:0] mem_m [3][256];
  int n_chk  = 0;
  int n_pass = 0;
  req_t bq[$];

  data_mem_ctrl #(.WAIT_CYCLES(0), .ALIGN_CHECK(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_we_i(req_we[0]), .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
    .load_type_i(ltype[0]), .store_type_i(stype[0]), .resp_valid_o(resp_valid[0]),
    .resp_rdata_o(resp_rdata[0]), .resp_err_o(resp_err[0]), .busy_o(busy[0]));

  data_mem_ctrl #(.WAIT_CYCLES(3), .ALIGN_CHECK(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_we_i(req_we[1]), .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
    .load_type_i(ltype[1]), .store_type_i(stype[1]), .resp_valid_o(resp_valid[1]),
    .resp_rdata_o(resp_rdata[1]), .resp_err_o(resp_err[1]), .busy_o(busy[1]));

  data_mem_ctrl #(.WAIT_CYCLES(2), .ALIGN_CHECK(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n[2]), .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]),
    .req_we_i(req_we[2]), .req_addr_i(req_addr[2]), .req_wdata_i(req_wdata[2]),
    .load_type_i(ltype[2]), .store_type_i(stype[2]), .resp_valid_o(resp_valid[2]),
    .resp_rdata_o(resp_rdata[2]), .resp_err_o(resp_err[2]), .busy_o(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic req_t mk(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                              input logic [2:0] lt, input logic [1:0] st);
    req_t r;
    r.we = we; r.addr = addr; r.wd = wd; r.lt = lt; r.st = st;
    return r;
  endfunction

  // Reference: size from the type code, error rules as plain arithmetic.
  function automatic void model(input int d, input req_t r,
                                output logic [31:0] rd, output logic er);
    logic [2:0] code;
    int sz;
    bit ill;
    longint v;
    code = r.we ? {1'b0, r.st} : r.lt;
    ill  = r.we ? (r.st == 2'd3) : (r.lt == 3'd3 || r.lt >= 3'd6);
    sz   = 1 << code[1:0];
    er   = ill || (int'(r.addr) + sz > 256) || (ac[d] && (int'(r.addr) % sz != 0));
    rd   = 32'h0;
    if (!er) begin
      if (r.we) begin
        for (int k = 0; k < sz; k++) mem_m[d][int'(r.addr) + k] = r.wd[8*k +: 8];
      end else begin
        v = 0;
        for (int k = 0; k < sz; k++) v = v + (longint'(mem_m[d][int'(r.addr) + k]) << (8*k));
        if (!r.lt[2] && v >= (longint'(1) << (8*sz - 1))) v = v - (longint'(1) << (8*sz));
        rd = v[31:0];
      end
    end
  endfunction

  task automatic drive(input int d, input req_t r);
    req_we[d] = r.we; req_addr[d] = r.addr; req_wdata[d] = r.wd;
    ltype[d] = r.lt; stype[d] = r.st; req_valid[d] = 1'b1;
  endtask

  // One isolated request with full timing checks of ready/busy/valid.
  task automatic txn(input int d, input req_t r, output logic [31:0] rd, output logic er);
    logic [31:0] erd;
    logic eer;
    int lat;
    @(negedge clk);
    chk("idle_ready", 32'(req_ready[d]), 32'd1);
    drive(d, r);
    model(d, r, erd, eer);
    @(negedge clk);
    req_valid[d] = 1'b0;
    lat = 1;
    while (!resp_valid[d] && lat < 40) begin
      chk("wait_ready", 32'(req_ready[d]), 32'd0);
      chk("wait_busy", 32'(busy[d]), 32'd1);
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(wc[d] + 1));
    chk("resp_busy", 32'(busy[d]), 32'd1);
    chk("resp_ready", 32'(req_ready[d]), 32'd1);
    chk("rdata", resp_rdata[d], erd);
    chk("err", 32'(resp_err[d]), 32'(eer));
    rd = resp_rdata[d];
    er = resp_err[d];
    @(negedge clk);
    chk("pulse_end", 32'(resp_valid[d]), 32'd0);
    chk("idle_busy", 32'(busy[d]), 32'd0);
  endtask

  // Back-to-back requests on the zero-wait instance, one per cycle.
  task automatic burst(output logic [31:0] last_rd);
    logic [31:0] e_rd [16];
    logic        e_er [16];
    last_rd = 32'h0;
    for (int i = 0; i <= bq.size(); i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("b2b_valid", 32'(resp_valid[0]), 32'd1);
        chk("b2b_rdata", resp_rdata[0], e_rd[i-1]);
        chk("b2b_err", 32'(resp_err[0]), 32'(e_er[i-1]));
        last_rd = resp_rdata[0];
      end
      if (i < bq.size()) begin
        chk("b2b_ready", 32'(req_ready[0]), 32'd1);
        drive(0, bq[i]);
        model(0, bq[i], e_rd[i], e_er[i]);
      end else begin
        req_valid[0] = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b_end", 32'(resp_valid[0]), 32'd0);
    bq.delete();
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    req_t r;
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 8'h0;
      req_wdata[d] = 32'h0; ltype[d] = 3'd0; stype[d] = 2'd0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_valid", 32'(resp_valid[d]), 32'd0);
      chk("rst_rdata", resp_rdata[d], 32'd0);
      chk("rst_err", 32'(resp_err[d]), 32'd0);
      chk("rst_busy", 32'(busy[d]), 32'd0);
      chk("rst_ready", 32'(req_ready[d]), 32'd1);
      rst_n[d] = 1'b1;
    end

    // Fill every instance through the port so all contents are known.
    for (int d = 0; d < 3; d++)
      for (int a = 0; a < 64; a++) txn(d, mk(1'b1, 8'(4*a), $urandom, 3'd0, 2'd2), rd, er);

    // Store then load in the following cycle.
    bq.push_back(mk(1'b1, 8'h10, 32'hDEADBEEF, 3'd0, 2'd2));
    bq.push_back(mk(1'b0, 8'h10, 32'h0, 3'd2, 2'd0));
    burst(rd);
    chk("sw_lw", rd, 32'hDEADBEEF);

    txn(0, mk(1'b0, 8'h13, 32'h0, 3'd0, 2'd0), rd, er); chk("lb",  rd, 32'hFFFFFFDE);
    txn(0, mk(1'b0, 8'h13, 32'h0, 3'd4, 2'd0), rd, er); chk("lbu", rd, 32'h000000DE);
    txn(0, mk(1'b0, 8'h12, 32'h0, 3'd1, 2'd0), rd, er); chk("lh",  rd, 32'hFFFFDEAD);
    txn(0, mk(1'b0, 8'h10, 32'h0, 3'd5, 2'd0), rd, er); chk("lhu", rd, 32'h0000BEEF);

    // Wait-state timing on the 3-cycle instance.
    txn(1, mk(1'b0, 8'h10, 32'h0, 3'd2, 2'd0), rd, er);

    // Error responses with alignment checking.
    txn(0, mk(1'b1, 8'h21, 32'hCAFEF00D, 3'd0, 2'd2), rd, er); chk("sw_mis_err", 32'(er), 32'd1);
    txn(0, mk(1'b0, 8'h20, 32'h0, 3'd2, 2'd0), rd, er);
    txn(0, mk(1'b0, 8'h24, 32'h0, 3'd2, 2'd0), rd, er);
    txn(0, mk(1'b0, 8'hFE, 32'h0, 3'd2, 2'd0), rd, er);
    chk("lw_range_err", 32'(er), 32'd1);
    chk("lw_range_rdata", rd, 32'h0);
    txn(0, mk(1'b0, 8'h30, 32'h0, 3'd3, 2'd0), rd, er); chk("lt3_err", 32'(er), 32'd1);

    // Byte-wise misaligned access without alignment checking.
    txn(2, mk(1'b1, 8'h21, 32'h0000A55A, 3'd0, 2'd1), rd, er); chk("sh_mis_err", 32'(er), 32'd0);
    txn(2, mk(1'b0, 8'h21, 32'h0, 3'd5, 2'd0), rd, er);        chk("lhu_mis", rd, 32'h0000A55A);

    // Reset while a store is still waiting: it must be dropped.
    @(negedge clk);
    drive(2, mk(1'b1, 8'h40, 32'h12345678, 3'd0, 2'd2));
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(negedge clk);
    rst_n[2] = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(resp_valid[2]), 32'd0);
    chk("mid_rst_busy", 32'(busy[2]), 32'd0);
    chk("mid_rst_ready", 32'(req_ready[2]), 32'd1);
    chk("mid_rst_rdata", resp_rdata[2], 32'd0);
    chk("mid_rst_err", 32'(resp_err[2]), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("in_rst_valid", 32'(resp_valid[2]), 32'd0);
    end
    rst_n[2] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(resp_valid[2]), 32'd0);
    end
    txn(2, mk(1'b0, 8'h40, 32'h0, 3'd2, 2'd0), rd, er);

    // Byte stores merging into one word, back to back.
    bq.push_back(mk(1'b1, 8'h50, 32'h00000011, 3'd0, 2'd0));
    bq.push_back(mk(1'b1, 8'h51, 32'h00000022, 3'd0, 2'd0));
    bq.push_back(mk(1'b1, 8'h52, 32'h00000033, 3'd0, 2'd0));
    bq.push_back(mk(1'b1, 8'h53, 32'h00000044, 3'd0, 2'd0));
    bq.push_back(mk(1'b0, 8'h50, 32'h0, 3'd2, 2'd0));
    burst(rd);
    chk("sb_merge", rd, 32'h44332211);

    // Random traffic, including random bursts on the zero-wait instance.
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 120; i++) begin
        r.we   = 1'($urandom_range(0, 1));
        r.addr = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(248, 255))
                                             : 8'($urandom_range(0, 255));
        r.wd   = $urandom;
        r.lt   = 3'($urandom_range(0, 7));
        r.st   = 2'($urandom_range(0, 3));
        if (d == 0 && (i % 10) == 9) begin
          for (int j = 0; j < 6; j++)
            bq.push_back(mk(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), $urandom,
                            3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))));
          burst(rd);
        end else begin
          txn(d, r, rd, er);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
